// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal branch predictor with BTB, mispredict check and counters
// Fetch-side lookup is combinational; execute-side resolution trains the entry at index(PCE).
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int XLEN     = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  PCF,
  output logic             PredTakenF,
  output logic [XLEN-1:0]  PredTargetF,
  input  logic             BranchE,
  input  logic             TakebranchE,
  input  logic             PredTakenE,
  input  logic [XLEN-1:0]  PredTargetE,
  input  logic [XLEN-1:0]  PCE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [XLEN-1:0]  PCPlus4E,
  output logic             MispredictE,
  output logic [XLEN-1:0]  PCRedirectE,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredictCount
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = XLEN - IDX_BITS - 2;

  logic [1:0]         ctr        [ENTRIES];
  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [XLEN-1:0]    btb_target [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, e_idx;
  logic [TAG_W-1:0]    f_tag, e_tag;
  logic                f_hit, e_hit, update;
  logic [1:0]          ctr_cur, ctr_next;
  logic                unused_pc_bits;

  assign f_idx = PCF[IDX_BITS+1:2];
  assign f_tag = PCF[XLEN-1:IDX_BITS+2];
  assign e_idx = PCE[IDX_BITS+1:2];
  assign e_tag = PCE[XLEN-1:IDX_BITS+2];
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign f_hit       = btb_valid[f_idx] & (btb_tag[f_idx] == f_tag);
  assign PredTakenF  = ctr[f_idx][1] & f_hit;
  assign PredTargetF = PredTakenF ? btb_target[f_idx] : PCF + XLEN'(4);

  assign MispredictE = BranchE & ~reset &
                       ((TakebranchE != PredTakenE) |
                        (TakebranchE & PredTakenE & (PredTargetE != PCTargetE)));
  assign PCRedirectE = TakebranchE ? PCTargetE : PCPlus4E;

  assign update  = BranchE & ~reset;
  assign e_hit   = btb_valid[e_idx] & (btb_tag[e_idx] == e_tag);
  assign ctr_cur = ctr[e_idx];

  // A taken branch that misses the BTB claims the entry as weakly taken.
  always_comb begin
    ctr_next = ctr_cur;
    if (TakebranchE) begin
      if (!e_hit)
        ctr_next = 2'b10;
      else if (ctr_cur != 2'b11)
        ctr_next = ctr_cur + 2'd1;
    end else if (ctr_cur != 2'b00) begin
      ctr_next = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        ctr[i] <= 2'b01;
      btb_valid       <= '0;
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else begin
      if (update) begin
        ctr[e_idx] <= ctr_next;
        if (TakebranchE)
          btb_valid[e_idx] <= 1'b1;
        if (BranchCount != '1)
          BranchCount <= BranchCount + CNT_W'(1);
      end
      if (MispredictE && (MispredictCount != '1))
        MispredictCount <= MispredictCount + CNT_W'(1);
    end
  end

  // Tag/target need no reset: they are qualified by btb_valid.
  always_ff @(posedge clk) begin
    if (update && TakebranchE) begin
      btb_tag[e_idx]    <= e_tag;
      btb_target[e_idx] <= PCTargetE;
    end
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and resolution checker for the pipelined RV32I core.
- Fetch side: a direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB) gives a taken/target prediction for PCF.
- Execute side: consumes the resolved branch outcome (Takebranch from the branch-condition logic, carried as TakebranchE) and the computed target. It trains the tables, flags mispredicts and supplies the redirect PC to the PC mux and hazard unit.

Parameters:
- IDX_BITS, 6, table index width; entries = 2^IDX_BITS.
- XLEN, 32, PC/target width.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- PCF  in  XLEN  fetch-stage PC being looked up.
- PredTakenF  out  1  prediction for PCF: taken.
- PredTargetF  out  XLEN  predicted target for PCF; equals PCF+4 when PredTakenF=0.
- BranchE  in  1  execute-stage instruction is a conditional branch.
- TakebranchE  in  1  resolved branch outcome.
- PredTakenE  in  1  PredTakenF for this instruction, piped F->E.
- PredTargetE  in  XLEN  PredTargetF for this instruction, piped F->E.
- PCE  in  XLEN  PC of the execute-stage instruction.
- PCTargetE  in  XLEN  computed branch target (PCE+imm).
- PCPlus4E  in  XLEN  PCE+4.
- MispredictE  out  1  prediction wrong; flush D/E and redirect.
- PCRedirectE  out  XLEN  correct next PC when MispredictE=1.
- BranchCount  out  CNT_W  resolved conditional branches.
- MispredictCount  out  CNT_W  mispredicts.

Behaviour:
- Index = PC[IDX_BITS+1:2]; tag = PC[XLEN-1:IDX_BITS+2].
- Per-entry state: ctr[1:0], btb_valid, btb_tag, btb_target.
- Reset is synchronous and takes priority over any update in the same cycle:
  - all ctr = 2'b01 (weakly not-taken);
  - all btb_valid = 0;
  - BranchCount = MispredictCount = 0.
- Reset asserted mid-stream discards any in-flight update. Outputs are valid the cycle after reset deasserts.
- Lookup is combinational from registered state, zero latency:
  - PredTakenF = ctr[idx][1] & btb_valid[idx] & (btb_tag[idx]==tag(PCF));
  - PredTargetF = PredTakenF ? btb_target[idx] : PCF+4 (mod 2^XLEN).
- Mispredict is combinational:
  - MispredictE = BranchE & ~reset & ((TakebranchE != PredTakenE) | (TakebranchE & PredTakenE & (PredTargetE != PCTargetE))).
  - PCRedirectE = TakebranchE ? PCTargetE : PCPlus4E, driven regardless of MispredictE.
  - With BranchE=0, MispredictE=0 (non-branches never predicted taken in E by construction; any PredTakenE is ignored).
- Update at the rising edge when BranchE=1 and reset=0, entry = index(PCE):
  - Counter transitions: 00->01->10->11 on taken; 11->10->01->00 on not-taken. Saturates at 11 on taken and at 00 on not-taken.
  - Taken: btb_valid=1, btb_tag=tag(PCE), btb_target=PCTargetE. This replaces any aliasing entry.
  - Not taken: BTB fields unchanged.
  - On a tag mismatch with a taken outcome, ctr is first reinitialised to 2'b10, then written (new entry, weakly taken).
- Read/write collision (PCF index == PCE index in the same cycle): lookup returns the pre-update value; the new value is visible next cycle.
- Counters:
  - BranchCount += 1 on each update cycle.
  - MispredictCount += 1 when MispredictE=1.
  - Both saturate at all-ones and never wrap.
- No stall input: the hazard unit must hold BranchE=0 on bubbles/flushed slots so each branch updates exactly once.

Test Plan:
- Reset: assert reset for 2 cycles. Then every PCF gives PredTakenF=0 and PredTargetF=PCF+4 (PCF=0x100 -> 0x104); both performance counters read 0.
- Cold taken branch: PCE=0x200, TakebranchE=1, PredTakenE=0, PCTargetE=0x180.
  - Same cycle: MispredictE=1, PCRedirectE=0x180.
  - Next cycle: PCF=0x200 gives PredTakenF=1, PredTargetF=0x180; counts read 1/1.
- Saturation: resolve 0x200 taken 4 more times with correct predictions -> ctr=11, MispredictE=0 each time. One not-taken -> ctr=10, PredTakenF still 1, MispredictE=1, PCRedirectE=0x204.
- Wrong target: PredTakenE=1, PredTargetE=0x180, TakebranchE=1, PCTargetE=0x1C0 -> MispredictE=1, PCRedirectE=0x1C0; BTB target updated to 0x1C0.
- Alias/collision: IDX_BITS=6, PCs 0x200 and 0x300 share index 0.
  - Taken update of 0x300 evicts 0x200 (0x200 lookup now PredTakenF=0).
  - Same-cycle lookup of 0x300 during its update returns the old value.
- Reset priority and saturation: reset asserted together with BranchE=1 -> no update, entry back to 01/invalid. Force MispredictCount to 0xFFFF, then mispredict -> stays 0xFFFF.
